// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline control encodings and helpers
package mips_pkg;

    // D-stage control-transfer type; codes 6 and 7 are reserved and decode as none
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BOVF = 3'd3,
        BR_J    = 3'd4,
        BR_JR   = 3'd5
    } br_type_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Branch byte offset: sign-extended word offset shifted left by two
    function automatic logic [31:0] sext_shift(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_target.sv
// rtl/npc_target.sv - combinational branch/jump take and target resolution
module npc_target
    import mips_pkg::*;
(
    input  logic [31:0] d_pc,
    input  logic [2:0]  d_br_type,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_index26,
    input  logic [31:0] d_rs_val,
    input  logic        cmp_zero,
    input  logic        cmp_ovf,
    output logic        take,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc4       = d_pc + 32'd4;
    assign br_target = pc4 + sext_shift(d_imm16);
    // Jump region comes from the delay-slot PC, so a jump in the last word of a
    // 256 MB region lands in the next region
    assign j_target  = {pc4[31:28], d_index26, 2'b00};

    // Decode the control type into a take decision and its redirect target
    always_comb begin
        take   = 1'b0;
        target = br_target;
        case (d_br_type)
            BR_BEQ: begin
                take   = cmp_zero;
                target = br_target;
            end
            BR_BNE: begin
                take   = ~cmp_zero;
                target = br_target;
            end
            BR_BOVF: begin
                take   = cmp_ovf;
                target = br_target;
            end
            BR_J: begin
                take   = 1'b1;
                target = j_target;
            end
            BR_JR: begin
                take   = 1'b1;
                target = d_rs_val;
            end
            default: begin
                take   = 1'b0;
                target = br_target;
            end
        endcase
    end

endmodule

// File: rtl/f_npc_ctrl.sv
// rtl/f_npc_ctrl.sv - F-stage PC, F/D register and branch redirect control
module f_npc_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          PC_STEP  = 4,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      f_instr,
    input  logic [2:0]       d_br_type,
    input  logic [15:0]      d_imm16,
    input  logic [25:0]      d_index26,
    input  logic [31:0]      d_rs_val,
    input  logic             cmp_zero,
    input  logic             cmp_ovf,
    output logic [31:0]      f_pc,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc8,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_cnt
);

    logic        take;
    logic [31:0] target;
    logic [31:0] next_pc;

    npc_target u_npc_target (
        .d_pc      (d_pc),
        .d_br_type (d_br_type),
        .d_imm16   (d_imm16),
        .d_index26 (d_index26),
        .d_rs_val  (d_rs_val),
        .cmp_zero  (cmp_zero),
        .cmp_ovf   (cmp_ovf),
        .take      (take),
        .target    (target)
    );

    // A stalled cycle may see stale comparator operands, so it never redirects
    assign redirect = take & ~stall;
    assign next_pc  = redirect ? target : (f_pc + 32'(PC_STEP));
    assign d_pc8    = d_pc + 32'd8;

    // PC, F/D register and redirect counter; the delay slot is never flushed
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc      <= PC_RESET;
            d_pc      <= 32'd0;
            d_instr   <= 32'd0;
            taken_cnt <= '0;
        end else if (!stall) begin
            f_pc      <= next_pc;
            d_pc      <= f_pc;
            d_instr   <= f_instr;
            taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, redirect};
        end
    end

endmodule

// File: tb/tb_f_npc_ctrl.sv
// tb/tb_f_npc_ctrl.sv - directed self-checking bench for f_npc_ctrl
module tb_f_npc_ctrl;
    import mips_pkg::*;

    localparam logic [31:0] IM_MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] f_instr;
    logic [2:0]  d_br_type;
    logic [15:0] d_imm16;
    logic [25:0] d_index26;
    logic [31:0] d_rs_val;
    logic        cmp_zero;
    logic        cmp_ovf;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [31:0] d_pc8;
    logic        redirect;
    logic [31:0] taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    // Instruction memory model: word content derived from its address
    always_comb f_instr = f_pc ^ IM_MASK;

    f_npc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .f_instr   (f_instr),
        .d_br_type (d_br_type),
        .d_imm16   (d_imm16),
        .d_index26 (d_index26),
        .d_rs_val  (d_rs_val),
        .cmp_zero  (cmp_zero),
        .cmp_ovf   (cmp_ovf),
        .f_pc      (f_pc),
        .d_pc      (d_pc),
        .d_instr   (d_instr),
        .d_pc8     (d_pc8),
        .redirect  (redirect),
        .taken_cnt (taken_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [2:0]  br;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        zero;
        logic        ovf;
        logic        stl;
        logic        exp_redir;
        logic [31:0] exp_fpc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        d_br_type = BR_NONE;
        d_imm16   = 16'd0;
        d_index26 = 26'd0;
        d_rs_val  = 32'd0;
        cmp_zero  = 1'b0;
        cmp_ovf   = 1'b0;
    endtask

    // Steer the pipeline so that the D stage holds address pc (f_pc = pc + 4)
    task automatic set_dpc(input logic [31:0] pc);
        idle_inputs();
        d_br_type = BR_JR;
        d_rs_val  = pc;
        #1;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"beq_taken",      32'h0000_3010, BR_BEQ,  16'h0003, 26'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3020};
        vecs[1]  = '{"beq_not_taken",  32'h0000_3010, BR_BEQ,  16'h0003, 26'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3018};
        vecs[2]  = '{"bne_back",       32'h0000_3100, BR_BNE,  16'hFFFE, 26'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_30FC};
        vecs[3]  = '{"bne_not_taken",  32'h0000_3100, BR_BNE,  16'hFFFE, 26'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3108};
        vecs[4]  = '{"bovf_taken",     32'h0000_3000, BR_BOVF, 16'h0001, 26'h0,       32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3008};
        vecs[5]  = '{"bovf_not_taken", 32'h0000_3000, BR_BOVF, 16'h0040, 26'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3008};
        vecs[6]  = '{"jal",            32'h0000_3FFC, BR_J,    16'h0000, 26'h0000C40, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3100};
        vecs[7]  = '{"jr",             32'h0000_3104, BR_JR,   16'h0000, 26'h0,       32'h0000_4004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4004};
        vecs[8]  = '{"jr_misaligned",  32'h0000_3200, BR_JR,   16'h0000, 26'h0,       32'h0000_1235, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1235};
        vecs[9]  = '{"reserved_type",  32'h0000_3300, 3'd6,    16'h0003, 26'h0,       32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3308};
        vecs[10] = '{"j_region_carry", 32'h1FFF_FFFC, BR_J,    16'h0000, 26'h0000001, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0004};
        vecs[11] = '{"beq_stalled",    32'h0000_3010, BR_BEQ,  16'h0003, 26'h0,       32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3014};

        // Reset held for two cycles, then sequential fetch
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_f_pc",      f_pc,      32'h0000_3000);
        check("rst_d_pc",      d_pc,      32'h0);
        check("rst_d_instr",   d_instr,   32'h0);
        check("rst_taken_cnt", taken_cnt, 32'h0);
        check("rst_redirect",  {31'd0, redirect}, 32'h0);
        check("rst_d_pc8",     d_pc8,     32'h8);
        reset = 1'b0;
        tick();
        check("seq_f_pc_1", f_pc, 32'h0000_3004);
        tick();
        check("seq_f_pc_2", f_pc, 32'h0000_3008);
        check("seq_d_instr", d_instr, 32'h0000_3004 ^ IM_MASK);

        // Table of single-cycle resolutions
        for (int i = 0; i < 12; i++) begin
            set_dpc(vecs[i].pc);
            d_br_type = vecs[i].br;
            d_imm16   = vecs[i].imm;
            d_index26 = vecs[i].idx;
            d_rs_val  = vecs[i].rs;
            cmp_zero  = vecs[i].zero;
            cmp_ovf   = vecs[i].ovf;
            stall     = vecs[i].stl;
            #1;
            check({vecs[i].name, "_d_pc"},     d_pc,  vecs[i].pc);
            check({vecs[i].name, "_d_pc8"},    d_pc8, vecs[i].pc + 32'd8);
            check({vecs[i].name, "_redirect"}, {31'd0, redirect}, {31'd0, vecs[i].exp_redir});
            tick();
            if (vecs[i].exp_redir) exp_cnt = exp_cnt + 32'd1;
            check({vecs[i].name, "_f_pc"},     f_pc,      vecs[i].exp_fpc);
            check({vecs[i].name, "_taken_cnt"}, taken_cnt, exp_cnt);
        end

        // Delay slot: the instruction after the bne still reaches D, then the target
        set_dpc(32'h0000_3100);
        d_br_type = BR_BNE;
        d_imm16   = 16'hFFFE;
        cmp_zero  = 1'b0;
        #1;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        idle_inputs();
        #1;
        check("ds_d_pc",    d_pc,    32'h0000_3104);
        check("ds_d_instr", d_instr, 32'h0000_3104 ^ IM_MASK);
        tick();
        check("ds_target_d_pc",    d_pc,    32'h0000_30FC);
        check("ds_target_d_instr", d_instr, 32'h0000_30FC ^ IM_MASK);

        // Stall for three cycles with taken beq conditions, then release
        set_dpc(32'h0000_3010);
        d_br_type = BR_BEQ;
        d_imm16   = 16'h0003;
        cmp_zero  = 1'b1;
        stall     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_redirect", {31'd0, redirect}, 32'h0);
            tick();
            check("stall_f_pc",      f_pc,      32'h0000_3014);
            check("stall_d_pc",      d_pc,      32'h0000_3010);
            check("stall_taken_cnt", taken_cnt, exp_cnt);
        end
        stall = 1'b0;
        #1;
        check("unstall_redirect", {31'd0, redirect}, 32'h1);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check("unstall_f_pc",      f_pc,      32'h0000_3020);
        check("unstall_taken_cnt", taken_cnt, exp_cnt);

        // Back-to-back: jump in the delay slot of a jump wins fetch
        set_dpc(32'h0000_3000);
        d_br_type = BR_JR;
        d_rs_val  = 32'h0000_5000;
        #1;
        tick();
        d_rs_val  = 32'h0000_6000;
        #1;
        check("b2b_redirect", {31'd0, redirect}, 32'h1);
        tick();
        exp_cnt = exp_cnt + 32'd2;
        idle_inputs();
        check("b2b_f_pc",      f_pc,      32'h0000_6000);
        check("b2b_d_pc",      d_pc,      32'h0000_5000);
        check("b2b_taken_cnt", taken_cnt, exp_cnt);

        // PC wraps at 2^32 on a sequential step
        set_dpc(32'hFFFF_FFF8);
        check("wrap_f_pc_pre", f_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_f_pc", f_pc, 32'h0000_0000);

        // Reset during a stall with a pending taken branch discards everything
        d_br_type = BR_BEQ;
        cmp_zero  = 1'b1;
        stall     = 1'b1;
        reset     = 1'b1;
        tick();
        exp_cnt = 32'd0;
        check("rst_stall_f_pc",      f_pc,      32'h0000_3000);
        check("rst_stall_d_pc",      d_pc,      32'h0);
        check("rst_stall_taken_cnt", taken_cnt, exp_cnt);
        reset = 1'b0;
        idle_inputs();
        tick();
        check("rst_stall_next_f_pc", f_pc, 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
